// File: rtl/irig_pkg.sv
// irig_pkg -- shared types and field limits for the IRIG time-of-day keeper.
// Rev 1.0
`default_nettype none
package irig_pkg;
  typedef enum logic [1:0] {
    ST_UNSYNC   = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_HOLDOVER = 2'd2
  } state_t;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HR_W   = 5;
  localparam int DAY_W  = 9;
  localparam int YEAR_W = 7;

  localparam int MAX_SEC  = 59;
  localparam int MAX_MIN  = 59;
  localparam int MAX_HR   = 23;
  localparam int MAX_YEAR = 99;

  // Last valid day-of-year; years divisible by four carry the extra day.
  function automatic logic [DAY_W-1:0] last_day(input logic [DAY_W-1:0] base,
                                                input logic [YEAR_W-1:0] year);
    return (year[1:0] == 2'b00) ? base + 9'd365 : base + 9'd364;
  endfunction
endpackage
`default_nettype wire

// File: rtl/irig_timekeeper_if.sv
// irig_timekeeper_if -- decoder-side inputs and time outputs of the timekeeper.
// Rev 1.0
`default_nettype none
interface irig_timekeeper_if #(
  parameter int SUBSEC_W = 32
);
  import irig_pkg::*;

  logic                in_pps;
  logic                in_time_valid;
  logic [SEC_W-1:0]    in_sec;
  logic [MIN_W-1:0]    in_min;
  logic [HR_W-1:0]     in_hr;
  logic [DAY_W-1:0]    in_day;
  logic [YEAR_W-1:0]   in_year;
  logic                resync;

  logic [SEC_W-1:0]    sec;
  logic [MIN_W-1:0]    min;
  logic [HR_W-1:0]     hr;
  logic [DAY_W-1:0]    day;
  logic [YEAR_W-1:0]   year;
  logic [SUBSEC_W-1:0] subsec;
  logic                pps_out;
  logic                time_valid;
  logic [1:0]          state;
  logic                resync_evt;
  logic [3:0]          mismatch_cnt;

  modport master (
    output in_pps, in_time_valid, in_sec, in_min, in_hr, in_day, in_year, resync,
    input  sec, min, hr, day, year, subsec, pps_out, time_valid, state,
           resync_evt, mismatch_cnt
  );

  modport slave (
    input  in_pps, in_time_valid, in_sec, in_min, in_hr, in_day, in_year, resync,
    output sec, min, hr, day, year, subsec, pps_out, time_valid, state,
           resync_evt, mismatch_cnt
  );
endinterface
`default_nettype wire

// File: rtl/irig_tod_incr.sv
// irig_tod_incr -- combinational next-second calculator with leap-year day wrap.
// Rev 1.0
`default_nettype none
module irig_tod_incr
  import irig_pkg::*;
#(
  parameter int DAY_BASE = 1
) (
  input  logic [SEC_W-1:0]  i_sec,
  input  logic [MIN_W-1:0]  i_min,
  input  logic [HR_W-1:0]   i_hr,
  input  logic [DAY_W-1:0]  i_day,
  input  logic [YEAR_W-1:0] i_year,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HR_W-1:0]   o_hr,
  output logic [DAY_W-1:0]  o_day,
  output logic [YEAR_W-1:0] o_year
);
  always_comb begin
    o_sec  = i_sec + SEC_W'(1);
    o_min  = i_min;
    o_hr   = i_hr;
    o_day  = i_day;
    o_year = i_year;
    if (i_sec >= SEC_W'(MAX_SEC)) begin
      o_sec = '0;
      o_min = i_min + MIN_W'(1);
      if (i_min >= MIN_W'(MAX_MIN)) begin
        o_min = '0;
        o_hr  = i_hr + HR_W'(1);
        if (i_hr >= HR_W'(MAX_HR)) begin
          o_hr  = '0;
          o_day = i_day + DAY_W'(1);
          if (i_day >= last_day(DAY_W'(DAY_BASE), i_year)) begin
            o_day  = DAY_W'(DAY_BASE);
            o_year = (i_year >= YEAR_W'(MAX_YEAR)) ? '0 : i_year + YEAR_W'(1);
          end
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/irig_timekeeper.sv
// irig_timekeeper -- time-of-day keeper with PPS qualification, holdover and resync.
// Rev 1.0
`default_nettype none
module irig_timekeeper
  import irig_pkg::*;
#(
  parameter int CLK_FREQ     = 100000000,
  parameter int SUBSEC_W     = 32,
  parameter int PPS_TOL      = 1000,
  parameter int HOLDOVER_MAX = 60,
  parameter int MISMATCH_LIM = 3,
  parameter int DAY_BASE     = 1
) (
  input logic             clk,
  input logic             rst,
  irig_timekeeper_if.slave bus
);
  localparam int HO_W = $clog2(HOLDOVER_MAX + 2);
  localparam logic [SUBSEC_W-1:0] c_win_lo  = SUBSEC_W'(CLK_FREQ - 1 - PPS_TOL);
  localparam logic [SUBSEC_W-1:0] c_timeout = SUBSEC_W'(CLK_FREQ - 1 + PPS_TOL);
  localparam logic [SUBSEC_W-1:0] c_period  = SUBSEC_W'(CLK_FREQ - 1);
  localparam logic [SUBSEC_W-1:0] c_tol     = SUBSEC_W'(PPS_TOL);

  state_t              r_state;
  logic [SEC_W-1:0]    r_sec;
  logic [MIN_W-1:0]    r_min;
  logic [HR_W-1:0]     r_hr;
  logic [DAY_W-1:0]    r_day;
  logic [YEAR_W-1:0]   r_year;
  logic [SUBSEC_W-1:0] r_subsec;
  logic                r_pps;
  logic                r_resync_evt;
  logic                r_resync_pend;
  logic [3:0]          r_mm_cnt;
  logic [HO_W-1:0]     r_ho_cnt;

  logic [SEC_W-1:0]    w_inc_sec;
  logic [MIN_W-1:0]    w_inc_min;
  logic [HR_W-1:0]     w_inc_hr;
  logic [DAY_W-1:0]    w_inc_day;
  logic [YEAR_W-1:0]   w_inc_year;

  logic                w_in_window, w_accept, w_timeout, w_ho_tick, w_tick, w_advance;
  logic                w_in_ok, w_differs, w_reload, w_unsync_load, w_load;
  logic [3:0]          w_mm_next;

  irig_tod_incr #(.DAY_BASE(DAY_BASE)) u_incr (
    .i_sec (r_sec),     .i_min (r_min),     .i_hr (r_hr),
    .i_day (r_day),     .i_year(r_year),
    .o_sec (w_inc_sec), .o_min (w_inc_min), .o_hr (w_inc_hr),
    .o_day (w_inc_day), .o_year(w_inc_year)
  );

  always_comb begin
    w_in_window = (r_subsec >= c_win_lo);
    w_accept    = bus.in_pps && ((r_state == ST_UNSYNC) || w_in_window);
    w_timeout   = (r_state == ST_LOCKED) && !w_accept && (r_subsec >= c_timeout);
    w_ho_tick   = (r_state == ST_HOLDOVER) && !w_accept && (r_subsec >= c_period);
    w_tick      = w_accept || w_timeout || w_ho_tick;
    w_advance   = w_tick && (r_state != ST_UNSYNC);

    w_in_ok = (bus.in_sec <= SEC_W'(MAX_SEC)) && (bus.in_min <= MIN_W'(MAX_MIN)) &&
              (bus.in_hr <= HR_W'(MAX_HR)) && (bus.in_year <= YEAR_W'(MAX_YEAR)) &&
              (bus.in_day >= DAY_W'(DAY_BASE)) &&
              (bus.in_day <= last_day(DAY_W'(DAY_BASE), bus.in_year));

    // Frames landing on a tick describe the second that tick just opened.
    w_differs = {bus.in_sec, bus.in_min, bus.in_hr, bus.in_day, bus.in_year} !=
                (w_advance ? {w_inc_sec, w_inc_min, w_inc_hr, w_inc_day, w_inc_year}
                           : {r_sec, r_min, r_hr, r_day, r_year});

    w_mm_next = (!w_in_ok || w_differs)
              ? ((r_mm_cnt == 4'hf) ? r_mm_cnt : r_mm_cnt + 4'd1) : 4'd0;

    w_reload      = (r_state != ST_UNSYNC) && bus.in_time_valid && w_in_ok &&
                    ((w_mm_next >= 4'(MISMATCH_LIM)) || r_resync_pend);
    w_unsync_load = (r_state == ST_UNSYNC) && bus.in_time_valid && w_in_ok;
    w_load        = w_reload || w_unsync_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_UNSYNC;
      r_sec         <= '0;
      r_min         <= '0;
      r_hr          <= '0;
      r_day         <= '0;
      r_year        <= '0;
      r_subsec      <= '0;
      r_pps         <= 1'b0;
      r_resync_evt  <= 1'b0;
      r_resync_pend <= 1'b0;
      r_mm_cnt      <= '0;
      r_ho_cnt      <= '0;
    end else begin
      r_pps         <= w_tick;
      r_resync_evt  <= w_reload && (r_state == ST_LOCKED);
      r_resync_pend <= bus.resync || (r_resync_pend && !w_load);

      if (w_accept || w_ho_tick)         r_subsec <= '0;
      else if (w_timeout)                r_subsec <= c_tol;
      else if (r_subsec != '1)           r_subsec <= r_subsec + SUBSEC_W'(1);

      if (w_load) begin
        r_sec  <= bus.in_sec;
        r_min  <= bus.in_min;
        r_hr   <= bus.in_hr;
        r_day  <= bus.in_day;
        r_year <= bus.in_year;
      end else if (w_advance) begin
        r_sec  <= w_inc_sec;
        r_min  <= w_inc_min;
        r_hr   <= w_inc_hr;
        r_day  <= w_inc_day;
        r_year <= w_inc_year;
      end

      if (w_load)
        r_mm_cnt <= '0;
      else if (bus.in_time_valid && (r_state != ST_UNSYNC))
        r_mm_cnt <= w_mm_next;

      case (r_state)
        ST_UNSYNC: begin
          if (w_unsync_load) begin
            r_state  <= ST_LOCKED;
            r_ho_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          if (w_timeout) begin
            r_state  <= ST_HOLDOVER;
            r_ho_cnt <= HO_W'(1);
          end
        end
        ST_HOLDOVER: begin
          if (w_accept) begin
            r_state  <= ST_LOCKED;
            r_ho_cnt <= '0;
          end else if (w_ho_tick) begin
            if (r_ho_cnt >= HO_W'(HOLDOVER_MAX)) begin
              r_state  <= ST_UNSYNC;
              r_ho_cnt <= '0;
            end else begin
              r_ho_cnt <= r_ho_cnt + HO_W'(1);
            end
          end
        end
        default: r_state <= ST_UNSYNC;
      endcase
    end
  end

  assign bus.sec          = r_sec;
  assign bus.min          = r_min;
  assign bus.hr           = r_hr;
  assign bus.day          = r_day;
  assign bus.year         = r_year;
  assign bus.subsec       = r_subsec;
  assign bus.pps_out      = r_pps;
  assign bus.time_valid   = (r_state != ST_UNSYNC);
  assign bus.state        = r_state;
  assign bus.resync_evt   = r_resync_evt;
  assign bus.mismatch_cnt = r_mm_cnt;
endmodule
`default_nettype wire

// File: tb/tb_irig_timekeeper.sv
// tb_irig_timekeeper -- directed self-checking bench for irig_timekeeper.
// Rev 1.0
`default_nettype none
module tb_irig_timekeeper;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   pps_count = 0;
  int   evt_count = 0;
  int   c0, e0;

  irig_timekeeper_if #(.SUBSEC_W(32)) bus ();

  irig_timekeeper #(
    .CLK_FREQ(100), .SUBSEC_W(32), .PPS_TOL(2),
    .HOLDOVER_MAX(3), .MISMATCH_LIM(3), .DAY_BASE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.pps_out)    pps_count++;
    if (bus.resync_evt) evt_count++;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse();
    bus.in_pps = 1'b1;
    step();
    bus.in_pps = 1'b0;
  endtask

  // Fills out one 100-cycle second after a pulse; the frame lands at subsec 9.
  task automatic second_with_tv(input int s, input int m, input int h,
                                input int d, input int y, input bit rs);
    idle(8);
    bus.resync = rs;
    step();
    bus.resync        = 1'b0;
    bus.in_time_valid = 1'b1;
    bus.in_sec        = 6'(s);
    bus.in_min        = 6'(m);
    bus.in_hr         = 5'(h);
    bus.in_day        = 9'(d);
    bus.in_year       = 7'(y);
    step();
    bus.in_time_valid = 1'b0;
    idle(89);
  endtask

  initial begin
    rst = 1'b1;
    bus.in_pps = 1'b0; bus.in_time_valid = 1'b0; bus.resync = 1'b0;
    bus.in_sec = '0; bus.in_min = '0; bus.in_hr = '0; bus.in_day = '0; bus.in_year = '0;
    idle(3);
    check("rst_state", bus.state, 0);
    check("rst_sec", bus.sec, 0);
    check("rst_subsec", bus.subsec, 0);
    check("rst_pps", bus.pps_out, 0);
    check("rst_tv", bus.time_valid, 0);
    check("rst_mm", bus.mismatch_cnt, 0);
    rst = 1'b0;

    // Initial lock and midnight/year rollover
    pulse();
    check("unsync_pps", bus.pps_out, 1);
    check("unsync_subsec", bus.subsec, 0);
    second_with_tv(58, 59, 23, 365, 23, 1'b0);
    check("lock_state", bus.state, 1);
    check("lock_tv", bus.time_valid, 1);
    check("lock_sec", bus.sec, 58);
    pulse();
    check("t1_sec", bus.sec, 59);
    check("t1_day", bus.day, 365);
    check("t1_pps", bus.pps_out, 1);
    idle(99);
    pulse();
    check("t2_sec", bus.sec, 0);
    check("t2_hr", bus.hr, 0);
    check("t2_day", bus.day, 1);
    check("t2_year", bus.year, 24);

    // Leap-year day 366 and its wrap, via forced resync
    e0 = evt_count;
    second_with_tv(59, 59, 23, 365, 24, 1'b1);
    check("rs_evt", evt_count - e0, 1);
    check("rs_sec", bus.sec, 59);
    check("rs_mm", bus.mismatch_cnt, 0);
    pulse();
    check("leap_day", bus.day, 366);
    check("leap_year", bus.year, 24);
    second_with_tv(59, 59, 23, 366, 24, 1'b1);
    pulse();
    check("leapwrap_day", bus.day, 1);
    check("leapwrap_year", bus.year, 25);
    check("leapwrap_hr", bus.hr, 0);

    // Glitch at subsec 40 is ignored
    idle(40);
    c0 = pps_count;
    pulse();
    check("glitch_subsec", bus.subsec, 41);
    check("glitch_sec", bus.sec, 0);
    idle(58);
    check("glitch_nopps", pps_count - c0, 0);
    check("glitch_subsec99", bus.subsec, 99);
    pulse();
    check("post_glitch_sec", bus.sec, 1);

    // Three offset frames force a reload
    e0 = evt_count;
    second_with_tv(6, 0, 0, 1, 25, 1'b0);
    check("mm1", bus.mismatch_cnt, 1);
    pulse();
    second_with_tv(7, 0, 0, 1, 25, 1'b0);
    check("mm2", bus.mismatch_cnt, 2);
    pulse();
    check("mm_sec_pre", bus.sec, 3);
    second_with_tv(8, 0, 0, 1, 25, 1'b0);
    check("mm_reload_sec", bus.sec, 8);
    check("mm_reload_cnt", bus.mismatch_cnt, 0);
    check("mm_evt_once", evt_count - e0, 1);
    pulse();
    second_with_tv(60, 0, 0, 1, 25, 1'b0);
    check("oor_mm", bus.mismatch_cnt, 1);
    check("oor_sec", bus.sec, 9);
    pulse();
    second_with_tv(10, 0, 0, 1, 25, 1'b0);
    check("eq_mm", bus.mismatch_cnt, 0);
    pulse();
    check("pre_ho_sec", bus.sec, 11);

    // Holdover through to UNSYNC
    idle(101);
    check("ho_wait_subsec", bus.subsec, 101);
    check("ho_wait_state", bus.state, 1);
    check("ho_wait_pps", bus.pps_out, 0);
    step();
    check("ho1_pps", bus.pps_out, 1);
    check("ho1_state", bus.state, 2);
    check("ho1_subsec", bus.subsec, 2);
    check("ho1_sec", bus.sec, 12);
    check("ho1_tv", bus.time_valid, 1);
    idle(97);
    check("ho2_wait_subsec", bus.subsec, 99);
    check("ho2_wait_pps", bus.pps_out, 0);
    step();
    check("ho2_pps", bus.pps_out, 1);
    check("ho2_sec", bus.sec, 13);
    check("ho2_subsec", bus.subsec, 0);
    idle(99);
    step();
    check("ho3_state", bus.state, 2);
    check("ho3_sec", bus.sec, 14);
    idle(99);
    step();
    check("ho4_pps", bus.pps_out, 1);
    check("ho4_state", bus.state, 0);
    check("ho4_tv", bus.time_valid, 0);
    check("ho4_sec", bus.sec, 15);
    idle(150);
    check("unsync_freeze_sec", bus.sec, 15);
    check("unsync_subsec", bus.subsec, 150);

    // Relock, enter holdover, recover with an in-window pulse
    pulse();
    second_with_tv(20, 0, 0, 1, 25, 1'b0);
    check("relock_state", bus.state, 1);
    check("relock_sec", bus.sec, 20);
    pulse();
    idle(101);
    step();
    check("ho_again_state", bus.state, 2);
    idle(96);
    pulse();
    check("recover_state", bus.state, 1);
    check("recover_subsec", bus.subsec, 0);
    check("recover_pps", bus.pps_out, 1);
    check("recover_sec", bus.sec, 23);

    // Async reset while in holdover
    idle(101);
    step();
    check("ho_pre_rst_state", bus.state, 2);
    check("ho_pre_rst_sec", bus.sec, 24);
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_sec", bus.sec, 0);
    check("arst_day", bus.day, 0);
    check("arst_year", bus.year, 0);
    check("arst_subsec", bus.subsec, 0);
    check("arst_pps", bus.pps_out, 0);
    check("arst_tv", bus.time_valid, 0);
    step();
    rst = 1'b0;
    pulse();
    second_with_tv(30, 10, 5, 100, 26, 1'b0);
    check("post_rst_state", bus.state, 1);
    check("post_rst_sec", bus.sec, 30);
    check("post_rst_min", bus.min, 10);
    check("post_rst_hr", bus.hr, 5);
    check("post_rst_day", bus.day, 100);
    check("post_rst_year", bus.year, 26);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/irig_timekeeper.md
Name: irig_timekeeper

Overview:
- Parametrised successor time-of-day keeper; sits after the IRIG-B bit/frame decoder.
- Consumes a per-frame decoded time strobe and the decoder's on-time PPS; keeps running sec/min/hr/day/year and a subsecond count.
- Adds leap-year day wrap, year field, glitch-rejecting PPS qualification, holdover with an internal PPS when the input drops, and mismatch-triggered resync.
- Outputs feed timestamping logic.

Parameters:
- CLK_FREQ, 100000000, clk cycles per nominal second.
- SUBSEC_W, 32, subsec width; must hold CLK_FREQ+PPS_TOL.
- PPS_TOL, 1000, cycles of PPS early/late tolerance.
- HOLDOVER_MAX, 60, seconds of holdover before dropping to UNSYNC.
- MISMATCH_LIM, 3, consecutive frame mismatches that force a reload.
- DAY_BASE, 1, first day-of-year value (IRIG = 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_pps  in  1  one-cycle on-time pulse from decoder.
- in_time_valid  in  1  one-cycle strobe: in_* fields label the second that began at the latest in_pps.
- in_sec  in  6  binary seconds 0-59.
- in_min  in  6  binary minutes 0-59.
- in_hr  in  5  binary hours 0-23.
- in_day  in  9  binary day-of-year.
- in_year  in  7  binary year 0-99.
- resync  in  1  force reload on next in_time_valid.
- sec  out  6  running seconds.
- min  out  6  running minutes.
- hr  out  5  running hours.
- day  out  9  running day-of-year.
- year  out  7  running year.
- subsec  out  SUBSEC_W  clk cycles since last accepted tick.
- pps_out  out  1  one-cycle tick: accepted in_pps, or synthesised in holdover.
- time_valid  out  1  high in LOCKED and HOLDOVER.
- state  out  2  0=UNSYNC, 1=LOCKED, 2=HOLDOVER.
- resync_evt  out  1  one-cycle pulse when a reload happens from LOCKED.
- mismatch_cnt  out  4  consecutive mismatch count.

Behaviour:
- Reset (async): all outputs 0, state UNSYNC. Internal mismatch and holdover counters 0; pending-resync flag 0.
- Outputs are registered, so the effect of an input appears 1 cycle after it is sampled.
- Increment (shared function):
  - sec wraps 59→0 and carries into min, min 59→0 into hr, hr 23→0 into day.
  - day wraps at DAY_BASE+364, or DAY_BASE+365 when year%4==0. The wrap value is DAY_BASE and carries into year.
  - year wraps 99→0.
- UNSYNC:
  - Every in_pps is accepted: pps_out=1 and subsec←0. Otherwise subsec increments, saturating at all-ones.
  - Time fields hold.
  - On in_time_valid: load in_* fields, go to LOCKED, mismatch_cnt←0.
- LOCKED:
  - in_pps is accepted only when subsec ≥ CLK_FREQ-1-PPS_TOL. An earlier pulse is ignored as a glitch: no tick, subsec continues.
  - On an accepted tick: pps_out=1, subsec←0, time increments.
  - On in_time_valid, compare in_* with running time. If a tick occurs in the same cycle, compare against the post-increment value.
    - Equal: mismatch_cnt←0.
    - Unequal: mismatch_cnt+1.
    - If the new count reaches MISMATCH_LIM, or the resync flag is set: load in_* (load overrides the increment), mismatch_cnt←0, resync_evt=1, clear the flag.
  - If subsec reaches CLK_FREQ-1+PPS_TOL with no accepted pulse:
    - Synthesise a tick: pps_out=1, time increments.
    - subsec←PPS_TOL, so the tick phase is preserved.
    - Go to HOLDOVER with holdover count←1.
- HOLDOVER:
  - Tick when subsec==CLK_FREQ-1, then subsec←0 and holdover count+1.
  - in_pps is qualified by the same window. A qualified in_pps gives a tick, subsec←0, LOCKED, holdover count←0.
  - in_time_valid in HOLDOVER is compared as in LOCKED.
  - When holdover count exceeds HOLDOVER_MAX, go to UNSYNC; time fields freeze.
- resync: sets a sticky flag, cleared by the next reload.
- Simultaneous tick and in_time_valid: load has priority over increment.
- in_time_valid with out-of-range fields (sec>59 etc.): ignored and counted as a mismatch.

Decomposition:
- Package irig_pkg:
  - state enum (UNSYNC, LOCKED, HOLDOVER).
  - field width constants (6/6/5/9/7).
  - MAX_SEC=59, MAX_MIN=59, MAX_HR=23, MAX_YEAR=99.
- Sub-module irig_tod_incr: combinational next-second calculator (fields in, incremented fields out, leap handling). Used once for the running time.

Test Plan (CLK_FREQ=100, PPS_TOL=2, HOLDOVER_MAX=3, MISMATCH_LIM=3, DAY_BASE=1):
- Initial lock:
  - Stimulus: in_pps every 100 cycles; in_time_valid 10 cycles after a pulse with 23:59:58, day 365, year 23.
  - Required: state=1. After the next 2 pulses: 23:59:59 d365, then 00:00:00 d1 y24.
- Leap-year wrap:
  - Stimulus: load 23:59:59, day 365, year 24, then one pulse.
  - Required: day=366, year=24. Next day-wrap gives day=1, year=25.
- Glitch rejection:
  - Stimulus: while locked, extra in_pps at subsec=40.
  - Required: no pps_out, sec unchanged, subsec keeps counting to 99.
- Holdover:
  - Stimulus: stop in_pps after a lock.
  - Required: pps_out at subsec 101 (state=2, subsec←2), then every 100 cycles. After the 4th missed tick, state=0 and time_valid=0.
  - Stimulus: restore in_pps within the window during holdover.
  - Required: state=1.
- Mismatch resync:
  - Stimulus: 3 consecutive frames whose in_sec is offset by +5.
  - Required: mismatch_cnt goes 1, 2, then a reload; resync_evt pulses once; sec equals in_sec; mismatch_cnt=0.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously in HOLDOVER.
  - Required: all outputs 0 immediately and state=0; the next frame relocks.
